// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder that reuses one DIGIT-bit adder slice for
// WIDTH/DIGIT cycles, LSB digit first, with a start/busy/done handshake.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a Sub input that turns the
// operation into A - B (A + ~B + 1); without it the block only adds.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  // N compute cycles; the counter keeps at least one bit so N=1 still elaborates.
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;

  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT-1:0] w_sum_dig;
  logic             w_carry_out;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // Operand B and the initial carry as seen by the slice; subtraction is
  // folded in here so the datapath itself never changes.
  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load     = Sub ? ~B : B;
  assign w_carry_load = Sub ? 1'b1 : Cin;
`else
  assign w_b_load     = B;
  assign w_carry_load = Cin;
`endif

  assign w_last = (r_cnt == CW'(N - 1));

  // Select the operand digits addressed by the digit counter.
  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int i = 0; i < N; i++) begin
      if (r_cnt == CW'(i)) begin
        w_a_dig = r_a[i*DIGIT +: DIGIT];
        w_b_dig = r_b[i*DIGIT +: DIGIT];
      end
    end
  end

  // The single shared DIGIT-bit adder slice.
  assign {w_carry_out, w_sum_dig} = {1'b0, w_a_dig} + {1'b0, w_b_dig}
                                  + {{DIGIT{1'b0}}, r_carry};

  // Result word with the current sum digit merged in, one lane per digit, so
  // the completion edge can publish the full sum including the last digit.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_res_lane
      assign w_res_next[gi*DIGIT +: DIGIT] =
        (r_cnt == CW'(gi)) ? w_sum_dig : r_res[gi*DIGIT +: DIGIT];
    end
  endgenerate

  // Control FSM with registered busy/done/S/Co; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      Co      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= w_b_load;
            r_carry <= w_carry_load;
            r_res   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_carry_out;
          if (w_last) begin
            S       <= w_res_next;
            Co      <= w_carry_out;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (DIGIT=1, 4 and 8 with WIDTH=8),
// expected {Co,S} pushed to a per-instance queue when an operation is issued
// and popped when done pulses.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DIGIT=1 instance
  logic       d1_start, d1_cin, d1_sub;
  logic [7:0] d1_a, d1_b;
  logic       d1_busy, d1_done, d1_co;
  logic [7:0] d1_s;
  // DIGIT=4 instance
  logic       d4_start, d4_cin, d4_sub;
  logic [7:0] d4_a, d4_b;
  logic       d4_busy, d4_done, d4_co;
  logic [7:0] d4_s;
  // DIGIT=8 instance (N=1)
  logic       d8_start, d8_cin, d8_sub;
  logic [7:0] d8_a, d8_b;
  logic       d8_busy, d8_done, d8_co;
  logic [7:0] d8_s;

  logic [8:0] q1[$];
  logic [8:0] q4[$];
  logic [8:0] q8[$];

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(d1_start), .A(d1_a), .B(d1_b), .Cin(d1_cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(d1_sub),
`endif
    .busy(d1_busy), .done(d1_done), .S(d1_s), .Co(d1_co)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(d4_start), .A(d4_a), .B(d4_b), .Cin(d4_cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(d4_sub),
`endif
    .busy(d4_busy), .done(d4_done), .S(d4_s), .Co(d4_co)
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(d8_start), .A(d8_a), .B(d8_b), .Cin(d8_cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(d8_sub),
`endif
    .busy(d8_busy), .done(d8_done), .S(d8_s), .Co(d8_co)
  );

  // Reference: exact 9-bit unsigned sum, or A + ~B + 1 when subtracting.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    logic [7:0] nb;
    nb = ~b;
    if (sub) return {1'b0, a} + {1'b0, nb} + 9'd1;
    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
  endfunction

  // Drives one accepting edge on the DIGIT=1 instance; returns #1 after edge 0.
  task automatic issue1(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub);
    logic eff_sub;
`ifdef SERIAL_ADDER_SUB_EN
    eff_sub = sub;
`else
    eff_sub = 1'b0;
`endif
    d1_a = a; d1_b = b; d1_cin = cin; d1_sub = sub; d1_start = 1'b1;
    @(posedge clk); #1;
    d1_start = 1'b0;
    q1.push_back(model(a, b, cin, eff_sub));
  endtask

  task automatic test_reset;
    checks++;
    if ({d1_busy, d1_done, d1_co, d1_s} !== 11'd0) begin
      errors++; $display("FAIL reset_d1: got %b required 0", {d1_busy, d1_done, d1_co, d1_s});
    end
    checks++;
    if ({d4_busy, d4_done, d4_co, d4_s} !== 11'd0) begin
      errors++; $display("FAIL reset_d4: got %b required 0", {d4_busy, d4_done, d4_co, d4_s});
    end
    checks++;
    if ({d8_busy, d8_done, d8_co, d8_s} !== 11'd0) begin
      errors++; $display("FAIL reset_d8: got %b required 0", {d8_busy, d8_done, d8_co, d8_s});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({d1_busy, d1_done} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset: busy/done=%b required 00", {d1_busy, d1_done});
    end
    $display("reset: outputs idle and zero");
  endtask

  task automatic test_basic;
    logic [8:0] exp;
    issue1(8'h5A, 8'hA5, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (d1_busy !== 1'b1 || d1_done !== 1'b0) begin
        errors++; $display("FAIL basic_busy_cycle%0d: busy=%b done=%b required busy=1 done=0", k, d1_busy, d1_done);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (d1_done !== 1'b1 || d1_busy !== 1'b0) begin
      errors++; $display("FAIL basic_latency: done=%b busy=%b required done=1 busy=0", d1_done, d1_busy);
    end
    exp = q1.pop_front();
    checks++;
    if ({d1_co, d1_s} !== exp) begin
      errors++; $display("FAIL basic_sum: got %h required %h", {d1_co, d1_s}, exp);
    end
    $display("basic: 5A+A5+0 -> Co=%b S=%h", d1_co, d1_s);
    @(posedge clk); #1;
    checks++;
    if (d1_done !== 1'b0 || {d1_co, d1_s} !== exp) begin
      errors++; $display("FAIL basic_hold: done=%b sum=%h required done=0 sum=%h", d1_done, {d1_co, d1_s}, exp);
    end
  endtask

  task automatic test_carry;
    logic [7:0] ta[2];
    logic [7:0] tb[2];
    logic       tc[2];
    logic [8:0] exp;
    int         n;
    ta[0] = 8'hFF; tb[0] = 8'h01; tc[0] = 1'b0;
    ta[1] = 8'h00; tb[1] = 8'h00; tc[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      issue1(ta[t], tb[t], tc[t], 1'b0);
      n = 0;
      while (d1_done !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if (d1_done !== 1'b1) begin
        errors++; $display("FAIL carry%0d_timeout: done=%b required 1", t, d1_done);
      end else begin
        exp = q1.pop_front();
        if ({d1_co, d1_s} !== exp) begin
          errors++; $display("FAIL carry%0d_sum: got %h required %h", t, {d1_co, d1_s}, exp);
        end
        $display("carry: %h+%h+%b -> Co=%b S=%h", ta[t], tb[t], tc[t], d1_co, d1_s);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_digit4;
    logic [8:0] exp;
    logic [7:0] cur_a, cur_b;
    logic       cur_cin;
    d4_a = 8'h7F; d4_b = 8'h81; d4_cin = 1'b1; d4_start = 1'b1;
    @(posedge clk); #1;
    d4_start = 1'b0;
    q4.push_back(model(8'h7F, 8'h81, 1'b1, 1'b0));
    checks++;
    if (d4_busy !== 1'b1 || d4_done !== 1'b0) begin
      errors++; $display("FAIL d4_busy0: busy=%b done=%b required 1 0", d4_busy, d4_done);
    end
    @(posedge clk); #1;
    checks++;
    if (d4_busy !== 1'b1 || d4_done !== 1'b0) begin
      errors++; $display("FAIL d4_busy1: busy=%b done=%b required 1 0", d4_busy, d4_done);
    end
    @(posedge clk); #1;
    exp = q4.pop_front();
    checks++;
    if (d4_done !== 1'b1 || {d4_co, d4_s} !== exp) begin
      errors++; $display("FAIL d4_sum: done=%b got %h required done=1 %h", d4_done, {d4_co, d4_s}, exp);
    end
    $display("digit4: 7F+81+1 -> Co=%b S=%h", d4_co, d4_s);
    @(posedge clk); #1;
    // Continuous start: accepts on cycles 0,3,6,..., done two cycles later.
    cur_a = 8'($urandom); cur_b = 8'($urandom); cur_cin = 1'($urandom);
    d4_a = cur_a; d4_b = cur_b; d4_cin = cur_cin; d4_start = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      if (c % 3 == 0) q4.push_back(model(cur_a, cur_b, cur_cin, 1'b0));
      checks++;
      if (d4_done !== (c % 3 == 2) || d4_busy !== (c % 3 != 2)) begin
        errors++; $display("FAIL d4_stream_c%0d: done=%b busy=%b required done=%b busy=%b", c, d4_done, d4_busy, (c % 3 == 2), (c % 3 != 2));
      end
      if (d4_done === 1'b1) begin
        exp = q4.pop_front();
        checks++;
        if ({d4_co, d4_s} !== exp) begin
          errors++; $display("FAIL d4_stream_sum_c%0d: got %h required %h", c, {d4_co, d4_s}, exp);
        end
        $display("stream: cycle %0d Co=%b S=%h", c, d4_co, d4_s);
      end
      cur_a = 8'($urandom); cur_b = 8'($urandom); cur_cin = 1'($urandom);
      d4_a = cur_a; d4_b = cur_b; d4_cin = cur_cin;
      if (c == 17) d4_start = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if (d4_busy !== 1'b0 || q4.size() != 0) begin
      errors++; $display("FAIL d4_stream_end: busy=%b pending=%0d required 0 0", d4_busy, q4.size());
    end
  endtask

  task automatic test_n1;
    logic [8:0] exp;
    d8_a = 8'hC3; d8_b = 8'h3C; d8_cin = 1'b1; d8_start = 1'b1;
    @(posedge clk); #1;
    d8_start = 1'b0;
    q8.push_back(model(8'hC3, 8'h3C, 1'b1, 1'b0));
    checks++;
    if (d8_busy !== 1'b1 || d8_done !== 1'b0) begin
      errors++; $display("FAIL n1_busy: busy=%b done=%b required 1 0", d8_busy, d8_done);
    end
    @(posedge clk); #1;
    exp = q8.pop_front();
    checks++;
    if (d8_busy !== 1'b0 || d8_done !== 1'b1 || {d8_co, d8_s} !== exp) begin
      errors++; $display("FAIL n1_sum: busy=%b done=%b got %h required 0 1 %h", d8_busy, d8_done, {d8_co, d8_s}, exp);
    end
    $display("n1: C3+3C+1 -> Co=%b S=%h", d8_co, d8_s);
    @(posedge clk); #1;
  endtask

  task automatic test_busy_reject;
    logic [8:0] exp;
    int         dones;
    issue1(8'h10, 8'h20, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    d1_a = 8'hFF; d1_b = 8'hFF; d1_start = 1'b1;
    @(posedge clk); #1;
    d1_start = 1'b0;
    checks++;
    if (d1_busy !== 1'b1) begin
      errors++; $display("FAIL reject_busy: busy=%b required 1", d1_busy);
    end
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      if (d1_done === 1'b1) begin
        dones++;
        if (q1.size() != 0) begin
          exp = q1.pop_front();
          checks++;
          if ({d1_co, d1_s} !== exp) begin
            errors++; $display("FAIL reject_sum: got %h required %h", {d1_co, d1_s}, exp);
          end
          $display("reject: 10+20 -> Co=%b S=%h", d1_co, d1_s);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL reject_done_count: got %0d required 1", dones);
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] exp;
    int         dones;
    int         n;
    issue1(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({d1_busy, d1_done, d1_co, d1_s} !== 11'd0) begin
      errors++; $display("FAIL midreset_clear: got %b required 0", {d1_busy, d1_done, d1_co, d1_s});
    end
    void'(q1.pop_back());
    #2 rst = 1'b0;
    @(posedge clk); #1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (d1_done === 1'b1 || d1_busy === 1'b1) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 0 || d1_s !== 8'h00) begin
      errors++; $display("FAIL midreset_quiet: activity=%0d S=%h required 0 00", dones, d1_s);
    end
    $display("midreset: aborted, S=%h", d1_s);
    issue1(8'h12, 8'h34, 1'b1, 1'b0);
    n = 0;
    while (d1_done !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (d1_done !== 1'b1) begin
      errors++; $display("FAIL midreset_restart_timeout: done=%b required 1", d1_done);
    end else begin
      exp = q1.pop_front();
      if ({d1_co, d1_s} !== exp) begin
        errors++; $display("FAIL midreset_restart_sum: got %h required %h", {d1_co, d1_s}, exp);
      end
      $display("restart: 12+34+1 -> Co=%b S=%h", d1_co, d1_s);
    end
    @(posedge clk); #1;
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_subtract;
    logic [7:0] ta[2];
    logic [7:0] tb[2];
    logic       tc[2];
    logic [8:0] exp;
    int         n;
    ta[0] = 8'h10; tb[0] = 8'h1A; tc[0] = 1'b0;
    ta[1] = 8'h1A; tb[1] = 8'h10; tc[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      issue1(ta[t], tb[t], tc[t], 1'b1);
      n = 0;
      while (d1_done !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if (d1_done !== 1'b1) begin
        errors++; $display("FAIL sub%0d_timeout: done=%b required 1", t, d1_done);
      end else begin
        exp = q1.pop_front();
        if ({d1_co, d1_s} !== exp) begin
          errors++; $display("FAIL sub%0d_diff: got %h required %h", t, {d1_co, d1_s}, exp);
        end
        $display("sub: %h-%h -> Co=%b S=%h", ta[t], tb[t], d1_co, d1_s);
      end
      @(posedge clk); #1;
    end
    d1_sub = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    d1_start = 1'b0; d1_a = '0; d1_b = '0; d1_cin = 1'b0; d1_sub = 1'b0;
    d4_start = 1'b0; d4_a = '0; d4_b = '0; d4_cin = 1'b0; d4_sub = 1'b0;
    d8_start = 1'b0; d8_a = '0; d8_b = '0; d8_cin = 1'b0; d8_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_carry();
    test_digit4();
    test_n1();
    test_busy_reject();
    test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
    test_subtract();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

- Parametrised, multi-cycle, digit-serial adder built around one DIGIT-bit full-adder slice that is reused every cycle.
- Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per cycle, LSB digit first, and saves the carry between cycles.
- Successor to the single-bit full adder: it extends that block to arbitrary word width and adds a start/busy/done handshake.
- Used wherever area matters more than latency.

## Interface

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 1.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT is the number of compute cycles.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled on the rising edge.
- A  input  WIDTH  operand A; sampled only on the accepting edge.
- B  input  WIDTH  operand B; sampled only on the accepting edge.
- Cin  input  1  carry-in; sampled only on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: S and Co have just been updated.
- S  output  WIDTH  sum; holds its value until the next completion.
- Co  output  1  carry-out of the MSB; holds like S.

## Operation

- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1. A digit counter cnt runs from 0 to N-1.
- Accept:
  - A rising edge with start=1 and busy=0 is an accepting edge.
  - On that edge the block latches A, B and Cin into internal shift and carry registers, clears cnt and moves to RUN.
- Start while busy=1 is ignored. Operands and the ongoing computation are unaffected.
- Each RUN edge:
  - The slice adds operand digits [cnt*DIGIT +: DIGIT] plus the stored carry.
  - It writes the sum digit to the internal result register and stores the new carry.
  - cnt then increments.
- Completion edge (cnt = N-1):
  - S ← full result.
  - Co ← final carry.
  - done ← 1.
  - State → IDLE.
- Arithmetic rule: {Co,S} = A + B + Cin, exactly (WIDTH+1)-bit, unsigned. No saturation.
- S and Co change only on completion edges or on reset. Partial sums are never visible on S.
- Reset (any time, including mid-RUN):
  - The operation is aborted with no completion.
  - State → IDLE.
  - busy=0, done=0, S=0, Co=0, cnt=0; internal registers cleared.
- Start held high continuously restarts a new operation every N+1 cycles, using whatever operands are present on each accepting edge.

## Timing

- Accepting edge = edge 0.
  - busy goes high after edge 0 and stays high through the cycle ending at edge N.
  - Digit k is processed on edge k+1, for k = 0..N-1.
- Latency: S/Co are valid and done=1 in the cycle following edge N, i.e. N cycles after the accepting edge.
- done is high for exactly one cycle. busy is 0 during that cycle.
- Back-to-back: start=1 in the done cycle is accepted.
  - Throughput is one operation per N+1 cycles.
  - If start is high continuously, done pulses every N+1 cycles.
- N=1 (DIGIT=WIDTH): busy is high for one cycle; done follows on the next edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration

- SERIAL_ADDER_SUB_EN defined:
  - Adds input port Sub (1 bit), latched on the accepting edge.
  - Sub=1: computes {Co,S} = A + ~B + 1. Cin is ignored and the initial carry is forced to 1.
  - In this mode Co=1 means no borrow (A ≥ B).
  - Sub=0: behaviour is identical to the plain adder.
- SERIAL_ADDER_SUB_EN undefined: Sub port absent; addition only.

## Test plan

- WIDTH=8, DIGIT=1:
  - Stimulus: A=8'h5A, B=8'hA5, Cin=0, start pulse.
  - Response: busy high for 8 cycles; done pulse 8 cycles after the accepting edge; S=8'hFF, Co=0.
- Carry ripple and carry-in (WIDTH=8, DIGIT=1):
  - A=8'hFF, B=8'h01, Cin=0 → S=8'h00, Co=1.
  - Then A=0, B=0, Cin=1 → S=8'h01, Co=0.
- DIGIT=4, WIDTH=8:
  - A=8'h7F, B=8'h81, Cin=1 → S=8'h01, Co=1 after 2 cycles.
  - Continuous start=1 gives a done pulse every 3 cycles.
- Busy rejection (WIDTH=8, DIGIT=1):
  - Start A=8'h10, B=8'h20; on cycle 3 pulse start with A=8'hFF, B=8'hFF.
  - Result S=8'h30, Co=0. Only one done pulse occurs.
- Reset mid-operation (WIDTH=8, DIGIT=1):
  - Assert rst asynchronously at cycle 4 of RUN, between clock edges.
  - busy, done, S and Co go to 0 immediately; no done pulse follows.
  - A new start afterwards completes normally.
- With SERIAL_ADDER_SUB_EN:
  - Sub=1, A=8'h10, B=8'h1A → S=8'hF6, Co=0.
  - Sub=1, A=8'h1A, B=8'h10, Cin=1 → S=8'h0A, Co=1 (Cin ignored).
